btn_debounce_ctrl: RTL and testbench



---
 rtl/btn_debounce_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_btn_debounce_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: multi-channel push-button controller with 2-FF input
// synchronisers, tick-based debounce, press/release events and per-channel
// interrupt enables with write-1-to-clear flags.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   Defined   : held, repeat-enabled channels re-raise their press flag after
//               REPEAT_DELAY ticks and then every REPEAT_RATE ticks.
//               Register 3 bits[31:16] hold the per-channel repeat enables.
//   Undefined : no repeat logic; register 3 bits[31:16] read as zero.
//
// Register map (addr[3:2]): 0 STATE, 1 IE, 2 IF (W1C), 3 RAW.
module btn_debounce_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int ADDR_BITS    = 4,
  parameter int TICK_DIV     = 100000,
  parameter int DEB_TICKS    = 8,
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_strb,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_en,
  output logic [31:0]          rd_data,
  input  logic [NUM_BTN-1:0]   btn_in,
  output logic                 irq
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam int              DW        = $clog2(DEB_TICKS + 1);
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [15:0]     CH_MASK   = 16'((33'd1 << NUM_BTN) - 33'd1);
  localparam logic [31:0]     REG_MASK  = {CH_MASK, CH_MASK};

  logic [NUM_BTN-1:0] sync_p0;
  logic [NUM_BTN-1:0] sync_p1;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press_evt;
  logic [NUM_BTN-1:0] release_evt;
  logic [NUM_BTN-1:0] rep_evt;
  logic [DW-1:0]      deb_cnt [NUM_BTN];
  logic [PW-1:0]      pre_cnt;
  logic               tick;
  logic [31:0]        ie_q;
  logic [31:0]        if_q;
  logic [31:0]        byte_mask;
  logic [31:0]        if_set;
  logic [31:0]        if_clr;
  logic [15:0]        press16;
  logic [15:0]        release16;
  logic [15:0]        rep_en_rd;
  logic               wr_ie;
  logic               wr_if;
  logic               unused_ok;

  assign byte_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign wr_ie     = wr_en && (wr_addr[3:2] == 2'd1);
  assign wr_if     = wr_en && (wr_addr[3:2] == 2'd2);
  assign tick      = (pre_cnt == TICK_LAST);
  assign unused_ok = ^{rd_en, wr_addr, rd_addr};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // Prescaler producing a one-cycle debounce tick every TICK_DIV clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Per-channel debounce; the event pulses line up with the first cycle the new stable value is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      stable      <= '0;
      press_evt   <= '0;
      release_evt <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      press_evt   <= '0;
      release_evt <= '0;
      if (tick) begin
        for (int i = 0; i < NUM_BTN; i++) begin
          if (sync_p1[i] != stable[i]) begin
            if (deb_cnt[i] == DEB_LAST) begin
              stable[i]      <= sync_p1[i];
              deb_cnt[i]     <= '0;
              press_evt[i]   <= sync_p1[i];
              release_evt[i] <= ~sync_p1[i];
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
          end else begin
            deb_cnt[i] <= '0;
          end
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            RW         = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]      rep_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] rep_armed;
  logic [15:0]        rep_en_q;
  logic               wr_rep;

  assign wr_rep    = wr_en && (wr_addr[3:2] == 2'd3);
  assign rep_en_rd = rep_en_q;

  // Repeat-enable register in the upper half of register 3
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_en_q <= '0;
    end else if (wr_rep) begin
      rep_en_q <= (rep_en_q & ~(byte_mask[31:16] & CH_MASK)) |
                  (wr_data[31:16] & byte_mask[31:16] & CH_MASK);
    end
  end

  // Repeat counters: initial delay after the press, then a fixed rate while held
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_evt   <= '0;
      rep_armed <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      rep_evt <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!stable[i]) begin
          rep_cnt[i]   <= '0;
          rep_armed[i] <= 1'b0;
        end else if (tick) begin
          if (!rep_armed[i]) begin
            if (rep_cnt[i] == DELAY_LAST) begin
              rep_cnt[i]   <= '0;
              rep_armed[i] <= 1'b1;
              rep_evt[i]   <= rep_en_q[i];
            end else begin
              rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
          end else if (rep_cnt[i] == RATE_LAST) begin
            rep_cnt[i] <= '0;
            rep_evt[i] <= rep_en_q[i];
          end else begin
            rep_cnt[i] <= rep_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign rep_evt   = '0;
  assign rep_en_rd = '0;
`endif

  // Widen the channel events to the 16-bit flag halves
  always_comb begin
    press16                  = '0;
    release16                = '0;
    press16[NUM_BTN-1:0]     = press_evt | rep_evt;
    release16[NUM_BTN-1:0]   = release_evt;
  end

  assign if_set = {release16, press16};
  assign if_clr = wr_if ? (wr_data & byte_mask) : 32'h0;

  // Interrupt enable register; bits of absent channels stay zero
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q <= '0;
    end else if (wr_ie) begin
      ie_q <= (ie_q & ~(byte_mask & REG_MASK)) | (wr_data & byte_mask & REG_MASK);
    end
  end

  // Interrupt flags: a set in the same cycle as a clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      if_q <= '0;
    end else begin
      if_q <= (if_q & ~if_clr) | if_set;
    end
  end

  assign irq = |(if_q & ie_q);

  // Read mux, free of side effects
  always_comb begin
    rd_data = '0;
    case (rd_addr[3:2])
      2'd0: rd_data[NUM_BTN-1:0] = stable;
      2'd1: rd_data = ie_q;
      2'd2: rd_data = if_q;
      default: begin
        rd_data[NUM_BTN-1:0] = sync_p1;
        rd_data[31:16]       = rep_en_rd;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Self-checking bench for btn_debounce_ctrl with a fast prescaler
// (TICK_DIV=4, DEB_TICKS=3). Register reads and irq probes queue their
// expected value; a negedge monitor pops and compares them.
module tb_btn_debounce_ctrl;

  localparam int NB = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [NB-1:0] btn_in;
  logic        irq;
  logic        irq_probe;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        is_irq;
    logic [31:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];

  btn_debounce_ctrl #(
    .NUM_BTN(NB), .ADDR_BITS(4), .TICK_DIV(4), .DEB_TICKS(3),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .btn_in(btn_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rd_en || irq_probe) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        item_t it;
        it = sb.pop_front();
        check(it.tag, it.is_irq ? {31'b0, irq} : rd_data, it.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic expect_reg(input logic [3:0] a, input logic [31:0] e, input string tag);
    sb.push_back('{1'b0, e, tag});
    rd_addr = a; rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic expect_irq(input logic e, input string tag);
    sb.push_back('{1'b1, {31'b0, e}, tag});
    irq_probe = 1'b1;
    step(1);
    irq_probe = 1'b0;
  endtask

  task automatic wait_reg(input logic [3:0] a, input logic [31:0] m, input logic [31:0] v,
                          input int bound, output int n, output bit ok);
    rd_addr = a; n = 0; ok = 1'b0;
    while (n < bound) begin
      step(1);
      n++;
      if ((rd_data & m) == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    bit ok;
    logic prev_irq;
    wr_addr = '0; wr_en = 0; wr_data = '0; wr_strb = '0;
    rd_addr = '0; rd_en = 0; btn_in = '0; irq_probe = 0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    expect_reg(4'h0, 32'h0, "rst_state");
    expect_reg(4'h4, 32'h0, "rst_ie");
    expect_reg(4'h8, 32'h0, "rst_if");
    expect_reg(4'hc, 32'h0, "rst_raw");
    expect_irq(1'b0, "rst_irq");

    // First press of ch0 with interrupts disabled
    btn_in[0] = 1'b1;
    wait_reg(4'h0, 32'h1, 32'h1, 40, n, ok);
    check("deb_wait", 32'(ok), 32'd1);
    check("deb_latency_in_9_15", 32'(n >= 9 && n <= 15), 32'd1);
    expect_reg(4'h0, 32'h1, "state_ch0");
    expect_reg(4'h8, 32'h1, "if_press0");
    expect_irq(1'b0, "irq_ie_off");
    expect_reg(4'hc, 32'h1, "raw_ch0");

    wr(4'h8, 32'h1, 4'hf);
    expect_reg(4'h8, 32'h0, "if_w1c");
    wr(4'h4, 32'hffff_ffff, 4'hf);
    expect_reg(4'h4, 32'h000f_000f, "ie_unused_zero");
    wr(4'h4, 32'h0, 4'b1100);
    expect_reg(4'h4, 32'h0000_000f, "ie_strb");
    wr(4'h4, 32'h1, 4'hf);
    expect_reg(4'h4, 32'h1, "ie_ch0");

    // Release ch0: release flag sets, but its enable is off
    btn_in[0] = 1'b0;
    wait_reg(4'h0, 32'h1, 32'h0, 40, n, ok);
    check("rel_wait", 32'(ok), 32'd1);
    step(2);
    expect_reg(4'h8, 32'h0001_0000, "if_rel0");
    expect_irq(1'b0, "irq_rel_masked");
    wr(4'h8, 32'h0001_0000, 4'b0100);
    expect_reg(4'h8, 32'h0, "if_clr_rel");

    // Press ch0 with IE: irq follows the flag, not before it
    btn_in[0] = 1'b1;
    rd_addr = 4'h8;
    prev_irq = irq;
    n = 0;
    while (n < 40 && !rd_data[0]) begin
      prev_irq = irq;
      step(1);
      n++;
    end
    check("irq_press_wait", {31'b0, rd_data[0]}, 32'd1);
    check("irq_before_if", {31'b0, prev_irq}, 32'd0);
    check("irq_with_if", {31'b0, irq}, 32'd1);
    wr(4'h8, 32'h1, 4'b1110);
    expect_reg(4'h8, 32'h1, "if_strb_keep");
    wr(4'h8, 32'h1, 4'b0001);
    expect_irq(1'b0, "irq_after_clr");

    // Release event coinciding with a W1C of the same flag
    btn_in[0] = 1'b0;
    wait_reg(4'h0, 32'h1, 32'h0, 40, n, ok);
    check("rel2_wait", 32'(ok), 32'd1);
    wr(4'h8, 32'h0001_0000, 4'hf);
    expect_reg(4'h8, 32'h0001_0000, "if_set_wins");
    wr(4'h8, 32'h0001_0000, 4'hf);
    expect_reg(4'h8, 32'h0, "if_clr2");

    // Bouncing ch1 never reaches the debounce count
    for (int k = 0; k < 10; k++) begin
      btn_in[1] = ~btn_in[1];
      step(5);
      expect_reg(4'h0, 32'h0, "bounce_state");
    end
    btn_in[1] = 1'b1;
    wait_reg(4'h0, 32'h2, 32'h2, 40, n, ok);
    check("ch1_wait", 32'(ok), 32'd1);
    check("ch1_latency_min", 32'(n >= 9), 32'd1);
    expect_reg(4'h0, 32'h2, "state_ch1");
    expect_reg(4'h8, 32'h2, "if_press1");

    // Reset in the middle of a ch2 debounce, buttons held through it
    wr(4'h8, 32'hffff_ffff, 4'hf);
    btn_in[2] = 1'b1;
    step(6);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    expect_reg(4'h0, 32'h0, "rst2_state");
    expect_reg(4'h4, 32'h0, "rst2_ie");
    expect_reg(4'h8, 32'h0, "rst2_if");
    expect_irq(1'b0, "rst2_irq");
    wait_reg(4'h8, 32'h6, 32'h6, 40, n, ok);
    check("fresh_wait", 32'(ok), 32'd1);
    check("fresh_full_debounce", 32'((n + 4) >= 11 && (n + 4) <= 16), 32'd1);
    expect_reg(4'h8, 32'h6, "if_fresh");

    // Upper half of register 3
    wr(4'hc, 32'hffff_0000, 4'hf);
`ifdef BTN_AUTOREPEAT_EN
    expect_reg(4'hc, 32'h000f_0006, "reg3_rep_en");
    wr(4'hc, 32'h0001_0000, 4'hf);
    wr(4'h8, 32'hffff_ffff, 4'hf);
    begin
      int t;
      int last;
      int nsets;
      int gaps[$];
      t = 0; last = -1; nsets = 0;
      btn_in[0] = 1'b1;
      rd_addr = 4'h8;
      while (t < 300 && nsets < 4) begin
        step(1);
        t++;
        if (rd_data[0]) begin
          if (last >= 0) gaps.push_back(t - last);
          last = t;
          nsets++;
          wr_addr = 4'h8; wr_data = 32'h1; wr_strb = 4'hf; wr_en = 1'b1;
          step(1);
          t++;
          wr_en = 1'b0;
        end
      end
      check("rep_sets", 32'(nsets), 32'd4);
      for (int i = 0; i < gaps.size(); i++) begin
        check("rep_gap", 32'(gaps[i]), (i == 0) ? 32'd16 : 32'd8);
      end
      btn_in[0] = 1'b0;
      wait_reg(4'h0, 32'h1, 32'h0, 40, n, ok);
      check("rep_rel_wait", 32'(ok), 32'd1);
      step(2);
      wr(4'h8, 32'hffff_ffff, 4'hf);
      step(40);
      expect_reg(4'h8, 32'h0, "rep_stop");
    end
`else
    expect_reg(4'hc, 32'h0000_0006, "reg3_no_rep");
`endif

    step(2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
